// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates the instruction-fetch and load/store ports onto a
// single-port byte-addressed RAM with one-cycle synchronous read latency.
// Each access runs IDLE -> ISSUE -> WAIT -> IDLE and acks with a one-cycle pulse.
module mem_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              I_clk,
    input  logic              I_reset,
    input  logic              I_fetch_req,
    input  logic [ADDR_W-1:0] I_fetch_addr,
    output logic [DATA_W-1:0] O_fetch_data,
    output logic              O_fetch_ack,
    input  logic              I_data_req,
    input  logic              I_data_write,
    input  logic [1:0]        I_data_size,
    input  logic              I_data_signed,
    input  logic [ADDR_W-1:0] I_data_addr,
    input  logic [DATA_W-1:0] I_data_in,
    output logic [DATA_W-1:0] O_data_out,
    output logic              O_data_ack,
    output logic              O_ram_enable,
    output logic              O_ram_write,
    output logic [1:0]        O_ram_size,
    output logic [ADDR_W-1:0] O_ram_addr,
    output logic [DATA_W-1:0] O_ram_data,
    input  logic [DATA_W-1:0] I_ram_data,
    output logic              O_busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic [1:0] SIZE_BYTE = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Byte lanes are fixed: low byte in [7:0], extension fills [15:8].
    function automatic logic [15:0] byte_extend(input logic [7:0] b, input logic sign_en);
        logic [15:0] r;
        if (sign_en) begin
            r = {{8{b[7]}}, b};
        end else begin
            r = {8'h00, b};
        end
        return r;
    endfunction

    logic [1:0]        state_r;
    logic              grant_data_r;   // 1 = data port owns the access in flight
    logic              cmd_write_r;
    logic              cmd_byte_r;
    logic              cmd_signed_r;

    logic              ram_enable_r;
    logic              ram_write_r;
    logic [1:0]        ram_size_r;
    logic [ADDR_W-1:0] ram_addr_r;
    logic [DATA_W-1:0] ram_data_r;
    logic [DATA_W-1:0] fetch_data_r;
    logic [DATA_W-1:0] data_out_r;
    logic              fetch_ack_r;
    logic              data_ack_r;

    logic              data_elig_s;
    logic              fetch_elig_s;
    logic [1:0]        data_size_s;
    logic [DATA_W-1:0] load_data_s;

    // Eligibility masks the ack cycle so a still-high req is not re-issued.
    always_comb begin
        data_elig_s  = I_data_req & ~data_ack_r;
        fetch_elig_s = I_fetch_req & ~fetch_ack_r;
        if (I_data_size == SIZE_BYTE) begin
            data_size_s = SIZE_BYTE;
        end else begin
            data_size_s = SIZE_WORD;
        end
    end

    // Format returned RAM data: byte loads ignore the upper RAM lane.
    always_comb begin
        load_data_s = I_ram_data;
        if (cmd_byte_r) begin
            load_data_s = byte_extend(I_ram_data[7:0], cmd_signed_r);
        end else begin
            load_data_s = I_ram_data;
        end
    end

    // Access sequencer: registers the winner's command, times the RAM, returns data and ack.
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state_r      <= ST_IDLE;
            grant_data_r <= 1'b0;
            cmd_write_r  <= 1'b0;
            cmd_byte_r   <= 1'b0;
            cmd_signed_r <= 1'b0;
            ram_enable_r <= 1'b0;
            ram_write_r  <= 1'b0;
            ram_size_r   <= 2'd0;
            ram_addr_r   <= '0;
            ram_data_r   <= '0;
            fetch_data_r <= '0;
            data_out_r   <= '0;
            fetch_ack_r  <= 1'b0;
            data_ack_r   <= 1'b0;
        end else begin
            fetch_ack_r <= 1'b0;
            data_ack_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (data_elig_s) begin
                        state_r      <= ST_ISSUE;
                        grant_data_r <= 1'b1;
                        cmd_write_r  <= I_data_write;
                        cmd_byte_r   <= (data_size_s == SIZE_BYTE);
                        cmd_signed_r <= I_data_signed;
                        ram_enable_r <= 1'b1;
                        ram_write_r  <= I_data_write;
                        ram_size_r   <= data_size_s;
                        ram_addr_r   <= I_data_addr;
                        ram_data_r   <= I_data_in;
                    end else if (fetch_elig_s) begin
                        state_r      <= ST_ISSUE;
                        grant_data_r <= 1'b0;
                        cmd_write_r  <= 1'b0;
                        cmd_byte_r   <= 1'b0;
                        cmd_signed_r <= 1'b0;
                        ram_enable_r <= 1'b1;
                        ram_write_r  <= 1'b0;
                        ram_size_r   <= SIZE_WORD;
                        ram_addr_r   <= I_fetch_addr;
                        ram_data_r   <= '0;
                    end else begin
                        state_r      <= ST_IDLE;
                        ram_enable_r <= 1'b0;
                        ram_write_r  <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    // RAM samples the command on this edge; strobes drop behind it.
                    state_r      <= ST_WAIT;
                    ram_enable_r <= 1'b0;
                    ram_write_r  <= 1'b0;
                end
                ST_WAIT: begin
                    state_r <= ST_IDLE;
                    if (grant_data_r) begin
                        data_ack_r <= 1'b1;
                        if (!cmd_write_r) begin
                            data_out_r <= load_data_s;
                        end else begin
                            data_out_r <= data_out_r;
                        end
                    end else begin
                        fetch_ack_r  <= 1'b1;
                        fetch_data_r <= I_ram_data;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    ram_enable_r <= 1'b0;
                    ram_write_r  <= 1'b0;
                end
            endcase
        end
    end

    // Outputs come straight from registers; busy is a pure state decode.
    always_comb begin
        O_ram_enable = ram_enable_r;
        O_ram_write  = ram_write_r;
        O_ram_size   = ram_size_r;
        O_ram_addr   = ram_addr_r;
        O_ram_data   = ram_data_r;
        O_fetch_data = fetch_data_r;
        O_fetch_ack  = fetch_ack_r;
        O_data_out   = data_out_r;
        O_data_ack   = data_ack_r;
        O_busy       = (state_r != ST_IDLE);
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller between the CPU core and the single-port byte-addressed RAM.
- Arbitrates two requesters: the instruction fetch port and the load/store data port.
- Sequences the RAM's enable/write/size strobes around its one-cycle synchronous read latency.
- Returns read data to the winning port with byte zero- or sign-extension, and acknowledges each access with a one-cycle pulse.

Parameters:
- ADDR_W, 16, address width on all ports.
- DATA_W, 16, data width on all ports. Must be 16; byte lanes are fixed at [7:0] and [15:8].

Ports:
- I_clk  in  1  system clock; all state updates on the rising edge.
- I_reset  in  1  synchronous, active-high reset.
- I_fetch_req  in  1  fetch request; held high until O_fetch_ack.
- I_fetch_addr  in  16  fetch address; stable while I_fetch_req is high.
- O_fetch_data  out  16  fetched word; valid while O_fetch_ack is high, then held.
- O_fetch_ack  out  1  one-cycle completion pulse for the fetch port.
- I_data_req  in  1  load/store request; held high until O_data_ack.
- I_data_write  in  1  1 = store, 0 = load.
- I_data_size  in  2  1 = byte, 2 = word; 0 and 3 are coerced to word.
- I_data_signed  in  1  byte loads only: 1 = sign-extend bit 7, 0 = zero-extend.
- I_data_addr  in  16  load/store address.
- I_data_in  in  16  store data; byte stores use [7:0].
- O_data_out  out  16  load result; valid while O_data_ack is high, then held.
- O_data_ack  out  1  one-cycle completion pulse for the data port.
- O_ram_enable  out  1  RAM enable strobe.
- O_ram_write  out  1  RAM write strobe.
- O_ram_size  out  2  RAM access size (1 or 2).
- O_ram_addr  out  16  RAM address.
- O_ram_data  out  16  RAM write data.
- I_ram_data  in  16  RAM read data; valid the cycle after the enabled read edge.
- O_busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset: all outputs 0, FSM goes to IDLE, grant register cleared.
- Reset mid-access aborts the access: no ack is issued and O_ram_enable drops on the same edge.
- FSM states: IDLE, ISSUE, WAIT.
- Eligibility in IDLE: a port is eligible if its req is high and its own ack is not high this cycle. This prevents re-issue on the ack cycle.
- IDLE -> ISSUE on edge N when any port is eligible.
  - Data port wins over fetch.
  - The winner's command is registered onto O_ram_*: enable=1, write, size, addr, data.
  - Fetch commands are always word reads.
- ISSUE -> WAIT on edge N+1; the RAM performs the access at this edge. O_ram_enable and O_ram_write drop to 0.
- WAIT -> IDLE on edge N+2.
  - Reads: I_ram_data is captured into the granted port's data output.
  - Ack is raised for exactly one cycle (N+2 to N+3).
  - Stores: ack as for reads; O_data_out is unchanged.
- Latency: request sampled at edge N, ack visible after edge N+2, for both reads and writes.
- Same-port back-to-back: the next request is sampled no earlier than edge N+3.
- Pending loser: if fetch lost arbitration, it is eligible at the next IDLE edge (N+2+1 = N+3) unless data is eligible again. Starvation of fetch under continuous data requests is permitted.
- Byte load extension: O_data_out[15:8] = {8{I_ram_data[7]}} if I_data_signed, else 8'h00. I_ram_data[15:8] is ignored for byte loads.
- Address and data width: the address passes through unmodified; misaligned word accesses are legal (the RAM handles addr+1). O_ram_data is I_data_in unchanged; the RAM ignores [15:8] on byte stores.
- Stability: all request fields are sampled only at the IDLE->ISSUE edge. Changes after that edge do not affect the access in flight.
- Request withdrawal: if a requester drops req before ack, the access still completes and acks.
- O_busy is decoded from the state register; no combinational path from inputs.

Test Plan:
- Reset, then fetch addr 0x0000 with RAM bytes [0]=0x00, [1]=0x80: O_fetch_data=0x8000 and O_fetch_ack high exactly 2 edges after the sampling edge, for one cycle.
- Simultaneous fetch 0x0002 and data word load 0x0000: data acks first with 0x8000. Fetch acks 3 edges later with 0x8C00 (bytes [2]=0x00, [3]=0x8C). O_ram_enable is never high on two consecutive cycles.
- Byte load 0x0001 ([1]=0x80): signed -> 0xFF80; unsigned -> 0x0080.
- Word store 0xBEEF to 0x0100, then signed byte load 0x0101 -> 0xFFBE; word load 0x0100 -> 0xBEEF. O_data_out is unchanged during the store ack.
- Size 0 load at 0x0000 behaves as a word load -> 0x8000. Size 3 store is written as a word.
- I_reset asserted in WAIT: no ack, O_busy=0 and all O_ram_* = 0 next cycle. A new request afterwards completes normally with 2-edge latency.
